// File: rtl/spi_ram_master_pkg.sv
// Shared definitions for the serial RAM master.
// Holds the opcodes sent in the first byte of every frame, the FSM
// state encoding, and the default sclk half-period in clk_i cycles.
package spi_ram_master_pkg;

  localparam logic [7:0]  OP_WRITE    = 8'h02;
  localparam logic [7:0]  OP_READ     = 8'h03;
  localparam int unsigned DEF_CLK_DIV = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/spi_ram_master_clk_tick.sv
// Half-period counter for the serial clock.
// Counts 0..DIV-1 while enabled and raises tick_o for one cycle on the
// terminal count. Held at 0 while disabled, so the first tick after
// enabling always lands DIV cycles later.
//   clk_i   system clock
//   nrst_i  asynchronous active-low reset
//   en_i    count enable
//   tick_o  one-cycle pulse on the terminal count
module spi_clk_tick #(
  parameter int unsigned DIV = 11
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// Transaction engine driving the serial RAM pins.
// Takes one read/write command, shifts a mode-0 MSB-first frame
// {opcode, addr, data} on cs/sclk/mosi, samples read data from miso and
// returns one response per command.
//   clk_i, nrst_i   clock, asynchronous active-low reset
//   cmd_*           command channel (valid/ready)
//   rsp_valid_o     one-cycle pulse at the end of every frame
//   rsp_rdata_o     read data, held until the next read response
//   cs_o/sclk_o/mosi_o/miso_i  serial RAM pins
//   dbg_state_o     current FSM state, for observation only
//
// Handshake: a command transfers on a rising clk_i edge where
// cmd_valid_i && cmd_ready_o; cmd_ready_o is high only in IDLE and
// the command inputs are not looked at any other time.
module spi_ram_master
  import spi_ram_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              cs_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output state_t            dbg_state_o
);

  localparam int unsigned NB         = 8 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W      = $clog2(NB);
  localparam int unsigned DATA_START = 8 + ADDR_W;

  state_t            state_q, state_d;
  logic [NB-1:0]     frame_q, frame_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NB-1:0]     cap_frame;
  logic              tick;

  // Read frames carry zeros in the data field, so mosi is 0 during read data.
  assign cap_frame = {(cmd_we_i ? OP_WRITE : OP_READ), cmd_addr_i,
                      (cmd_we_i ? cmd_wdata_i : {DATA_W{1'b0}})};

  spi_clk_tick #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    we_d        = we_q;
    bit_d       = bit_q;
    rd_d        = rd_q;
    cs_d        = cs_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          frame_d = cap_frame;
          we_d    = cmd_we_i;
          bit_d   = '0;
          rd_d    = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = cap_frame[NB-1];
          ready_d = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // miso is taken on the edge that ends the high phase.
            if (!we_q && (bit_q >= CNT_W'(DATA_START))) begin
              rd_d = (rd_q << 1) | DATA_W'(miso_i);
            end
            if (bit_q == CNT_W'(NB - 1)) begin
              mosi_d  = 1'b0;
              state_d = ST_TAIL;
            end else begin
              frame_d = frame_q << 1;
              mosi_d  = frame_q[NB-2];
              bit_d   = bit_q + 1'b1;
            end
          end
        end
      end
      ST_TAIL: begin
        if (tick) begin
          cs_d    = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          rsp_valid_d = 1'b1;
          ready_d     = 1'b1;
          if (!we_q) begin
            rdata_d = rd_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      we_q        <= 1'b0;
      bit_q       <= '0;
      rd_q        <= '0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      we_q        <= we_d;
      bit_q       <= bit_d;
      rd_q        <= rd_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign cs_o        = cs_q;
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master with a behavioural serial RAM slave.
module tb_spi_ram_master;
  import spi_ram_master_pkg::*;

  localparam int CLK_DIV = 11;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int NB      = 8 + ADDR_W + DATA_W;
  // Cycle offsets from the handshake cycle T.
  localparam int T_RISE0 = 1 + CLK_DIV;
  localparam int T_CS_HI = 1 + CLK_DIV * (2 * NB + 1);
  localparam int T_RSP   = 1 + CLK_DIV * (2 * NB + 2);

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic nrst_i;
  always #5 clk_i = ~clk_i;

  logic              cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              cs_o, sclk_o, mosi_o;
  logic              miso = 1'b0;
  state_t            dbg_state;

  spi_ram_master #(
    .CLK_DIV (CLK_DIV),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_i       (clk_i),
    .nrst_i      (nrst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .cs_o        (cs_o),
    .sclk_o      (sclk_o),
    .mosi_o      (mosi_o),
    .miso_i      (miso),
    .dbg_state_o (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- serial RAM model ----------------
  logic [7:0]    mem [256];
  logic [NB-1:0] ram_rx = '0;
  logic [NB-1:0] last_frame = '0;
  logic [7:0]    ram_op = '0, ram_addr = '0, ram_byte;
  int            ram_cnt = 0;

  initial begin : ram_model
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    forever begin
      @(posedge sclk_o or posedge cs_o);
      if (cs_o) begin
        ram_cnt = 0;
        miso    = 1'b0;
      end else begin
        ram_rx = {ram_rx[NB-2:0], mosi_o};
        if (ram_cnt == 15) begin
          ram_op   = ram_rx[15:8];
          ram_addr = ram_rx[7:0];
        end
        if (ram_cnt >= 16) begin
          if (ram_op == 8'h03) begin
            ram_byte = mem[ram_addr];
            miso     = ram_byte[7 - (ram_cnt - 16)];
          end
          if (ram_cnt == NB - 1) begin
            last_frame = ram_rx;
            if (ram_op == 8'h02) mem[ram_addr] = ram_rx[7:0];
          end
        end
        ram_cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  int               hs_q[$];
  logic [DATA_W-1:0] got_q[$];
  int               rsp_cyc_q[$];
  int cs_rise_cyc = 0, cs_fall_cyc = 0, gap_cyc = 0;
  int first_rise_cyc = 0, rise_cnt = 0, idle_sclk = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0;

  always @(negedge clk_i) begin
    if (nrst_i && cmd_valid_i && cmd_ready_o) hs_q.push_back(cyc);
    if (!cs_o && cs_prev) begin
      cs_fall_cyc = cyc;
      gap_cyc     = cyc - cs_rise_cyc;
      rise_cnt    = 0;
    end
    if (cs_o && !cs_prev) cs_rise_cyc = cyc;
    if (sclk_o && !sclk_prev) begin
      if (rise_cnt == 0) first_rise_cyc = cyc;
      rise_cnt++;
    end
    if (cs_o && sclk_o) idle_sclk++;
    if (rsp_valid_o) begin
      got_q.push_back(rsp_rdata_o);
      rsp_cyc_q.push_back(cyc);
    end
    cs_prev   = cs_o;
    sclk_prev = sclk_o;
  end

  // ---------------- scoreboard / checks ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] rdata_model;
  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic we, input logic [7:0] addr, input logic [7:0] data);
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = data;
    cmd_valid_i = 1'b1;
  endtask

  // Returns just after the posedge that captured the command.
  task automatic wait_hs(output int c);
    c = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i);
      if (hs_q.size() > 0) break;
    end
    check("hs_seen", 64'(hs_q.size() > 0), 1);
    if (hs_q.size() > 0) c = hs_q.pop_front();
  endtask

  task automatic wait_rsp(input string tag, input int t);
    logic [DATA_W-1:0] d;
    int c;
    for (int i = 0; i < 3000; i++) begin
      if (got_q.size() > 0) break;
      @(posedge clk_i);
    end
    check("rsp_seen", 64'(got_q.size() > 0), 1);
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      d = got_q.pop_front();
      c = rsp_cyc_q.pop_front();
      check({tag, "_rdata"}, d, exp_q.pop_front());
      check({tag, "_rsp_time"}, 64'(c - t), T_RSP);
    end
  endtask

  // Issue one command, record its expected response and wait for it.
  task automatic run_cmd(input string tag, input logic we, input logic [7:0] addr,
                         input logic [7:0] data, output int t);
    @(posedge clk_i); #1;
    drive_cmd(we, addr, data);
    wait_hs(t);
    #1 cmd_valid_i = 1'b0;
    if (!we) rdata_model = mem[addr];
    exp_q.push_back(rdata_model);
    wait_rsp(tag, t);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int t, t1, t2;
    nrst_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
    cmd_addr_i = '0; cmd_wdata_i = '0; rdata_model = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cs", cs_o, 1);
    check("rst_sclk", sclk_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    check("rst_state", dbg_state, ST_IDLE);
    nrst_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check("idle_cs", cs_o, 1);
    check("idle_ready", cmd_ready_o, 1);
    check("idle_no_sclk", 64'(rise_cnt), 0);

    // Write 0x5A <- 0xC3, full timing
    run_cmd("wr5a", 1'b1, 8'h5A, 8'hC3, t);
    check("wr5a_first_rise", 64'(first_rise_cyc - t), T_RISE0);
    check("wr5a_cs_high", 64'(cs_rise_cyc - t), T_CS_HI);
    check("wr5a_frame", last_frame, 24'h025AC3);
    check("wr5a_mem", mem[8'h5A], 8'hC3);
    #1;
    check("wr5a_pulse_one_cycle", rsp_valid_o, 0);
    check("wr5a_ready_back", cmd_ready_o, 1);

    // Read 0x10 (preloaded 0xA5) and read back the written byte
    run_cmd("rd10", 1'b0, 8'h10, 8'h5F, t);
    check("rd10_frame", last_frame, 24'h031000);
    check("rd10_rdata_held", rsp_rdata_o, 8'hA5);
    run_cmd("rd5a", 1'b0, 8'h5A, 8'h00, t);

    // Back-to-back with cmd_valid_i held high
    @(posedge clk_i); #1;
    drive_cmd(1'b1, 8'h33, 8'h77);
    wait_hs(t1);
    #1 drive_cmd(1'b0, 8'h33, 8'h00);
    exp_q.push_back(rdata_model);
    wait_hs(t2);
    #1 cmd_valid_i = 1'b0;
    rdata_model = 8'h77;
    exp_q.push_back(rdata_model);
    wait_rsp("b2b_wr", t1);
    wait_rsp("b2b_rd", t2);
    check("b2b_accept_on_rsp", 64'(t2 - t1), T_RSP);
    // cs high from T+T_CS_HI until the next frame's first cycle T2+1.
    check("b2b_cs_gap", 64'(gap_cyc), CLK_DIV + 1);

    // Busy ignore: a different command pulsed mid-frame
    @(posedge clk_i); #1;
    drive_cmd(1'b0, 8'h5A, 8'h00);
    wait_hs(t);
    #1 cmd_valid_i = 1'b0;
    rdata_model = mem[8'h5A];
    exp_q.push_back(rdata_model);
    repeat (100) @(posedge clk_i);
    #1 drive_cmd(1'b1, 8'h5A, 8'hEE);
    repeat (5) @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    wait_rsp("busy_rd", t);
    repeat (800) @(posedge clk_i);
    check("busy_no_extra_rsp", 64'(got_q.size()), 0);
    check("busy_no_extra_hs", 64'(hs_q.size()), 0);
    check("busy_frame", last_frame, 24'h035A00);
    check("busy_mem", mem[8'h5A], 8'hC3);

    // Reset in the middle of a write frame
    @(posedge clk_i); #1;
    drive_cmd(1'b1, 8'h44, 8'h99);
    wait_hs(t);
    #1 cmd_valid_i = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk_i);
      if (rise_cnt >= 11) break;
    end
    check("abort_bit10_reached", 64'(rise_cnt >= 11), 1);
    #3 nrst_i = 1'b0;
    #1;
    check("abort_cs", cs_o, 1);
    check("abort_sclk", sclk_o, 0);
    check("abort_ready", cmd_ready_o, 1);
    repeat (3) @(posedge clk_i);
    #1 nrst_i = 1'b1;
    rdata_model = '0;
    repeat (1200) @(posedge clk_i);
    check("abort_no_rsp", 64'(got_q.size()), 0);
    check("abort_mem_untouched", mem[8'h44], 8'h00);

    run_cmd("post_wr44", 1'b1, 8'h44, 8'h99, t);
    check("post_first_rise", 64'(first_rise_cyc - t), T_RISE0);
    check("post_cs_high", 64'(cs_rise_cyc - t), T_CS_HI);
    check("post_frame", last_frame, 24'h024499);
    run_cmd("post_rd44", 1'b0, 8'h44, 8'h00, t);

    check("never_sclk_with_cs_high", 64'(idle_sclk), 0);
    check("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
